snax_cgra_csr_manager: RTL and testbench
========================================

// Module: snax_cgra_csr_manager
// PURPOSE
//  CSR responder on the CGRA side of the simplified CSR req/rsp channel driven by the SNAX front-end.
//  Holds the RW configuration CSRs, RO status/perf CSRs and the start/busy/done handshake to the CGRA.
//  Returns one response per read; writes are acknowledged at accept and produce no response.
//  A 2-entry response FIFO decouples reads from SNAX response back-pressure.
// PARAMETERS
//  NumRwCsr   8   RW CSR count; addr 0..NumRwCsr-1; addr NumRwCsr-1 is the START CSR
//  NumRoCsr   2   RO CSR count; addr NumRwCsr = status (bit0 busy), NumRwCsr+1 = perf cycle count
//  DataWidth  64  CSR data width
//  AddrWidth  32  CSR address width
// PORTS
//  clk_i                    in   1                  clock
//  rst_ni                   in   1                  async active-low reset
//  io_csr_req_bits_data_i   in   DataWidth          write data
//  io_csr_req_bits_addr_i   in   AddrWidth          CSR index (already offset-corrected upstream)
//  io_csr_req_bits_write_i  in   1                  1 = write, 0 = read
//  io_csr_req_valid_i       in   1                  request valid
//  io_csr_req_ready_o       out  1                  request accepted when valid&ready
//  io_csr_rsp_valid_o       out  1                  read response valid
//  io_csr_rsp_ready_i       in   1                  response consumed when valid&ready
//  io_csr_rsp_bits_data_o   out  DataWidth          read data
//  csr_rw_set_o             out  NumRwCsr*DataWidth RW CSRs flattened, CSR i at [i*DataWidth +: DataWidth]
//  cgra_start_o             out  1                  1-cycle start pulse to CGRA
//  cgra_done_i              in   1                  1-cycle completion pulse from CGRA
// BEHAVIOUR
//  Reset: all RW CSRs 0, busy 0, perf 0, FIFO empty; rsp_valid_o 0, cgra_start_o 0.
//  Req ready (combinational on valid/write/state):
//   - read:  ready = !fifo_full; no same-cycle pop bypass.
//   - write: ready = !busy; writes stall for the whole run.
//  Write accept:
//   - addr < NumRwCsr-1: CSR updated next edge.
//   - addr == NumRwCsr-1: CSR stores data; bit0=1 pulses cgra_start_o next cycle and sets busy.
//   - RO or out-of-range addr: silently dropped.
//  Read accept: data pushed to FIFO; rsp_valid_o asserts the next cycle (latency 1).
//   - RW addr: current CSR value.
//   - status addr: {63'b0, busy} (zero-extended to DataWidth).
//   - perf addr: perf counter.
//   - out-of-range: 0.
//   - RW read the same cycle as a write to it: impossible, both are on one channel.
//  Responses are returned in request order.
//  Busy FSM, IDLE -> RUN:
//   - IDLE -> RUN on START write with bit0=1; perf cleared to 0 on that transition.
//   - RUN: perf += 1 each cycle, saturating at all-ones.
//   - RUN -> IDLE on cgra_done_i; done in IDLE is ignored.
//   - done in the start-pulse cycle is honoured (busy clears next edge).
//  FIFO: 2 entries, registered outputs.
//   - push and pop in the same cycle with 1 entry: occupancy stays 1.
//   - full: read ready low until a pop completes.
//   - rsp data is stable while valid&!ready.
//  Reset mid-operation: async clear of all state; pending responses discarded, no start pulse.
// STRUCTURE
//  Package snax_cgra_csr_pkg:
//   - csr_data_t, csr_addr_t
//   - localparams StartCsrIdx, StatusCsrIdx, PerfCsrIdx
//   - busy_state_e {IDLE, RUN}
//  Sub-module snax_cgra_csr_rsp_fifo: 2-deep valid/ready FIFO, DataWidth wide, async active-low reset.
//  Top level contains: address decode, RW register array, busy FSM, perf counter.
// TESTING
//  1 Write 0xDEAD_BEEF to addr 2, then read addr 2 -> one rsp, data 0xDEAD_BEEF, 1 cycle after accept.
//  2 Write 1 to addr 7 -> start pulse of exactly 1 cycle; status read = 1.
//    Write to addr 0 while busy -> ready low until done.
//    After done in 5 busy cycles -> status = 0, perf = 5.
//  3 Hold rsp_ready=0, issue 3 reads -> 2 accepted, 3rd stalls.
//    Release -> 3 responses in order, no loss or duplication.
//  4 Read addr 0x40 -> data 0. Write addr 8 (RO) -> accepted, status unchanged.
//  5 Start, then done in the start-pulse cycle -> busy clears next edge, no hang.
//  6 Assert rst_ni low mid-run with 1 pending response -> rsp_valid 0, busy 0, CSRs 0 immediately.

Source files
------------

// File: rtl/snax_cgra_csr_pkg.sv
// Shared types and default configuration for the SNAX CGRA CSR manager.
// CSR index constants below describe the default 8 RW + 2 RO map.
package snax_cgra_csr_pkg;

   localparam int unsigned NumRwCsrDefault  = 8;
   localparam int unsigned NumRoCsrDefault  = 2;
   localparam int unsigned DataWidthDefault = 64;
   localparam int unsigned AddrWidthDefault = 32;

   localparam int unsigned StartCsrIdx  = NumRwCsrDefault - 1;
   localparam int unsigned StatusCsrIdx = NumRwCsrDefault;
   localparam int unsigned PerfCsrIdx   = NumRwCsrDefault + 1;

   typedef logic [DataWidthDefault-1:0] csr_data_t;
   typedef logic [AddrWidthDefault-1:0] csr_addr_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } busy_state_e;

endpackage

// File: rtl/snax_cgra_csr_rsp_fifo.sv
// Two-entry valid/ready response FIFO. The head entry is always held in head_reg,
// so the output data comes straight from a register and stays put while stalled.
module snax_cgra_csr_rsp_fifo #(
   parameter int unsigned Width = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [Width-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [Width-1:0] pop_data
);

   logic [Width-1:0] head_reg;
   logic [Width-1:0] tail_reg;
   logic [1:0]       count_reg;
   logic             push;
   logic             pop;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign push_ready = (count_reg != 2'd2);
   assign pop_valid  = (count_reg != 2'd0);
   assign pop_data   = head_reg;

   assign push = push_valid && push_ready;
   assign pop  = pop_valid && pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_reg == 2'd0) begin
                  head_reg <= push_data;
               end else begin
                  tail_reg <= push_data;
               end
               count_reg <= count_reg + 2'd1;
            end
            2'b01: begin
               head_reg  <= tail_reg;
               count_reg <= count_reg - 2'd1;
            end
            2'b11: begin
               // Only reachable with one entry: the new word replaces the departing head.
               head_reg <= push_data;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/snax_cgra_csr_manager.sv
// CGRA-side CSR responder: RW config registers, status/perf read-only CSRs,
// start/busy/done handshake and an in-order read response queue.
module snax_cgra_csr_manager
   import snax_cgra_csr_pkg::*;
#(
   parameter int unsigned NumRwCsr  = NumRwCsrDefault,
   parameter int unsigned NumRoCsr  = NumRoCsrDefault,
   parameter int unsigned DataWidth = DataWidthDefault,
   parameter int unsigned AddrWidth = AddrWidthDefault
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [DataWidth-1:0]          io_csr_req_bits_data_i,
   input  logic [AddrWidth-1:0]          io_csr_req_bits_addr_i,
   input  logic                          io_csr_req_bits_write_i,
   input  logic                          io_csr_req_valid_i,
   output logic                          io_csr_req_ready_o,
   output logic                          io_csr_rsp_valid_o,
   input  logic                          io_csr_rsp_ready_i,
   output logic [DataWidth-1:0]          io_csr_rsp_bits_data_o,
   output logic [NumRwCsr*DataWidth-1:0] csr_rw_set_o,
   output logic                          cgra_start_o,
   input  logic                          cgra_done_i
);

   localparam int unsigned IdxWidth = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
   localparam logic [AddrWidth-1:0] StartAddr  = AddrWidth'(NumRwCsr - 1);
   localparam logic [AddrWidth-1:0] StatusAddr = AddrWidth'(NumRwCsr);
   localparam logic [AddrWidth-1:0] PerfAddr   = AddrWidth'(NumRwCsr + 1);
   localparam logic [AddrWidth-1:0] RoEndAddr  = AddrWidth'(NumRwCsr + NumRoCsr);

   logic [NumRwCsr-1:0][DataWidth-1:0] rw_view;
   logic [IdxWidth-1:0]                rw_idx;
   logic                               rw_hit;
   logic                               ro_hit;
   logic                               start_hit;
   logic                               wr_accept;
   logic                               rd_accept;
   logic                               fifo_ready;
   logic [DataWidth-1:0]               rd_data;
   logic [DataWidth-1:0]               perf_reg;
   logic [DataWidth-1:0]               perf_next;
   busy_state_e                        state_reg;
   busy_state_e                        state_next;
   logic                               start_reg;
   logic                               start_next;
   logic                               busy;

   assign busy = (state_reg == RUN);

   // Address decode
   assign rw_hit = (io_csr_req_bits_addr_i < AddrWidth'(NumRwCsr));
   assign ro_hit = (io_csr_req_bits_addr_i >= StatusAddr) &&
                   (io_csr_req_bits_addr_i < RoEndAddr);
   assign rw_idx = io_csr_req_bits_addr_i[IdxWidth-1:0];

   // Writes are held off for the whole run; reads only wait on queue space.
   assign io_csr_req_ready_o = io_csr_req_bits_write_i ? !busy : fifo_ready;
   assign wr_accept = io_csr_req_valid_i && io_csr_req_ready_o && io_csr_req_bits_write_i;
   assign rd_accept = io_csr_req_valid_i && io_csr_req_ready_o && !io_csr_req_bits_write_i;

   assign start_hit = wr_accept && (io_csr_req_bits_addr_i == StartAddr) &&
                      io_csr_req_bits_data_i[0];

   // RW register array
   for (genvar gi = 0; gi < NumRwCsr; gi++) begin : g_rw_csr
      logic [DataWidth-1:0] value_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            value_reg <= '0;
         end else if (wr_accept && (io_csr_req_bits_addr_i == AddrWidth'(gi))) begin
            value_reg <= io_csr_req_bits_data_i;
         end
      end

      assign rw_view[gi] = value_reg;
   end

   assign csr_rw_set_o = rw_view;

   always_comb begin
      rd_data = '0;
      if (rw_hit) begin
         rd_data = rw_view[rw_idx];
      end else if (ro_hit) begin
         if (io_csr_req_bits_addr_i == StatusAddr) begin
            rd_data = DataWidth'(busy);
         end else if (io_csr_req_bits_addr_i == PerfAddr) begin
            rd_data = perf_reg;
         end
      end
   end

   // Busy FSM and perf counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         start_reg <= 1'b0;
         perf_reg  <= '0;
      end else begin
         state_reg <= state_next;
         start_reg <= start_next;
         perf_reg  <= perf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start_next = 1'b0;
      perf_next  = perf_reg;
      case (state_reg)
         IDLE: begin
            if (start_hit) begin
               state_next = RUN;
               start_next = 1'b1;
               perf_next  = '0;
            end
         end
         RUN: begin
            if (perf_reg != '1) begin
               perf_next = perf_reg + 1'b1;
            end
            // The first RUN cycle is also the start-pulse cycle, so an
            // immediate done is honoured here too.
            if (cgra_done_i) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign cgra_start_o = start_reg;

   snax_cgra_csr_rsp_fifo #(
      .Width(DataWidth)
   ) u_rsp_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .push_valid(rd_accept),
      .push_ready(fifo_ready),
      .push_data (rd_data),
      .pop_valid (io_csr_rsp_valid_o),
      .pop_ready (io_csr_rsp_ready_i),
      .pop_data  (io_csr_rsp_bits_data_o)
   );

endmodule

// File: tb/tb_snax_cgra_csr_manager.sv
// Bench for snax_cgra_csr_manager: directed scenarios with literal expectations
// followed by random traffic, all checked against a behavioural model every cycle.
module tb_snax_cgra_csr_manager;
   import snax_cgra_csr_pkg::*;

   localparam int NRW = 8;
   localparam int DW  = 64;
   localparam int AW  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DW-1:0]     req_data = '0;
   logic [AW-1:0]     req_addr = '0;
   logic              req_write = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DW-1:0]     rsp_data;
   logic [NRW*DW-1:0] csr_rw_set;
   logic              cgra_start;
   logic              cgra_done = 1'b0;

   always #5 clk = ~clk;

   snax_cgra_csr_manager #(
      .NumRwCsr (NRW),
      .NumRoCsr (2),
      .DataWidth(DW),
      .AddrWidth(AW)
   ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .io_csr_req_bits_data_i (req_data),
      .io_csr_req_bits_addr_i (req_addr),
      .io_csr_req_bits_write_i(req_write),
      .io_csr_req_valid_i     (req_valid),
      .io_csr_req_ready_o     (req_ready),
      .io_csr_rsp_valid_o     (rsp_valid),
      .io_csr_rsp_ready_i     (rsp_ready),
      .io_csr_rsp_bits_data_o (rsp_data),
      .csr_rw_set_o           (csr_rw_set),
      .cgra_start_o           (cgra_start),
      .cgra_done_i            (cgra_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [63:0] m_csr [NRW];
   logic        m_busy = 1'b0;
   logic        m_start = 1'b0;
   logic [63:0] m_perf = '0;
   logic [63:0] m_q[$];
   logic [63:0] obs[$];

   function automatic bit model_ready();
      return req_write ? !m_busy : (m_q.size() < 2);
   endfunction

   function automatic logic [63:0] model_read(input logic [AW-1:0] a);
      if (a < AW'(NRW)) return m_csr[a[2:0]];
      if (a == AW'(StatusCsrIdx)) return {63'b0, m_busy};
      if (a == AW'(PerfCsrIdx)) return m_perf;
      return 64'd0;
   endfunction

   initial begin
      bit          acc;
      bit          pop;
      logic [63:0] rd;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < NRW; i++) m_csr[i] = '0;
            m_busy = 1'b0;
            m_start = 1'b0;
            m_perf = '0;
            m_q.delete();
         end else begin
            acc = req_valid && model_ready();
            pop = (m_q.size() != 0) && rsp_ready;
            rd  = model_read(req_addr);
            m_start = 1'b0;
            if (m_busy) begin
               if (m_perf != '1) m_perf = m_perf + 64'd1;
               if (cgra_done) m_busy = 1'b0;
            end
            if (acc && req_write) begin
               if (req_addr < AW'(NRW)) m_csr[req_addr[2:0]] = req_data;
               if (req_addr == AW'(StartCsrIdx) && req_data[0]) begin
                  m_busy = 1'b1;
                  m_perf = '0;
                  m_start = 1'b1;
               end
            end
            if (pop) void'(m_q.pop_front());
            if (acc && !req_write) m_q.push_back(rd);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (req_valid) check("req_ready", 64'(req_ready), 64'(model_ready()));
            check("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) check("rsp_data", rsp_data, m_q[0]);
            check("cgra_start", 64'(cgra_start), 64'(m_start));
            for (int i = 0; i < NRW; i++) check("csr_rw_set", csr_rw_set[i*DW +: DW], m_csr[i]);
            if (rsp_valid && rsp_ready) obs.push_back(rsp_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int c;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_data  = d;
      c = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         c++;
         if (c >= 50) begin
            check("req_accept", 64'(req_ready), 64'd1);
            break;
         end
      end
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n0;
      int unsigned r;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_start", 64'(cgra_start), 64'd0);
      check("rst_rd_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < NRW; i++) check("rst_csr", csr_rw_set[i*DW +: DW], 64'd0);
      rst_n = 1'b1;
      tick();

      // 1: write then read back, one cycle latency
      issue(1'b1, 32'd2, 64'hDEAD_BEEF);
      issue(1'b0, 32'd2, 64'd0);
      @(negedge clk);
      check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      check("t1_rsp_data", rsp_data, 64'hDEAD_BEEF);
      tick();

      // 2: start, status while busy, stalled write, done after 5 busy cycles
      issue(1'b1, 32'd7, 64'd1);                    // busy cycle 1
      @(negedge clk);
      check("t2_start_pulse", 64'(cgra_start), 64'd1);
      tick();                                       // busy cycle 2
      check("t2_start_once", 64'(cgra_start), 64'd0);
      issue(1'b0, 32'd8, 64'd0);                    // now busy cycle 3
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd0; req_data = 64'd5;
      @(negedge clk);
      check("t2_status_busy", rsp_data, 64'd1);
      check("t2_wr_stall", 64'(req_ready), 64'd0);
      tick();                                       // busy cycle 4
      @(negedge clk);
      check("t2_wr_stall", 64'(req_ready), 64'd0);
      tick();                                       // busy cycle 5
      cgra_done = 1'b1;
      @(negedge clk);
      check("t2_wr_stall", 64'(req_ready), 64'd0);
      tick();
      cgra_done = 1'b0;
      @(negedge clk);
      check("t2_wr_resume", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      issue(1'b0, 32'd9, 64'd0);
      @(negedge clk);
      check("t2_perf", rsp_data, 64'd5);
      tick();
      issue(1'b0, 32'd8, 64'd0);
      @(negedge clk);
      check("t2_status_idle", rsp_data, 64'd0);
      tick();

      // 3: back-pressure, full queue, in-order drain
      rsp_ready = 1'b0;
      issue(1'b0, 32'd0, 64'd0);
      issue(1'b0, 32'd2, 64'd0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd7;
      repeat (3) begin
         @(negedge clk);
         check("t3_full_stall", 64'(req_ready), 64'd0);
         check("t3_hold_data", rsp_data, 64'd5);
         tick();
      end
      n0 = obs.size();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t3_no_bypass", 64'(req_ready), 64'd0);
      tick();
      issue(1'b0, 32'd7, 64'd0);
      repeat (4) tick();
      check("t3_rsp_count", 64'(obs.size() - n0), 64'd3);
      if (obs.size() - n0 == 3) begin
         check("t3_rsp0", obs[n0], 64'd5);
         check("t3_rsp1", obs[n0+1], 64'hDEAD_BEEF);
         check("t3_rsp2", obs[n0+2], 64'd1);
      end

      // 4: out-of-range read, write to RO CSR
      issue(1'b0, 32'h40, 64'd0);
      @(negedge clk);
      check("t4_oor_valid", 64'(rsp_valid), 64'd1);
      check("t4_oor_data", rsp_data, 64'd0);
      tick();
      issue(1'b1, 32'd8, 64'd1);
      issue(1'b0, 32'd8, 64'd0);
      @(negedge clk);
      check("t4_status", rsp_data, 64'd0);
      tick();

      // 5: done in the start-pulse cycle
      issue(1'b1, 32'd7, 64'd1);
      cgra_done = 1'b1;
      @(negedge clk);
      check("t5_start_pulse", 64'(cgra_start), 64'd1);
      tick();
      cgra_done = 1'b0;
      issue(1'b0, 32'd8, 64'd0);
      @(negedge clk);
      check("t5_status", rsp_data, 64'd0);
      tick();
      issue(1'b0, 32'd9, 64'd0);
      @(negedge clk);
      check("t5_perf", rsp_data, 64'd1);
      tick();

      // 6: reset mid-run with a pending response
      issue(1'b1, 32'd3, 64'h1234);
      issue(1'b1, 32'd7, 64'd1);
      rsp_ready = 1'b0;
      issue(1'b0, 32'd3, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
      check("t6_start", 64'(cgra_start), 64'd0);
      check("t6_csr3", csr_rw_set[3*DW +: DW], 64'd0);
      check("t6_csr7", csr_rw_set[7*DW +: DW], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick();
      issue(1'b0, 32'd8, 64'd0);
      @(negedge clk);
      check("t6_status", rsp_data, 64'd0);
      tick();
      issue(1'b0, 32'd9, 64'd0);
      @(negedge clk);
      check("t6_perf", rsp_data, 64'd0);
      tick();

      // Random traffic against the model
      repeat (3000) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 15);
         req_addr  = (r < 12) ? AW'(r) : AW'($urandom());
         req_data  = {$urandom(), $urandom()};
         rsp_ready = ($urandom_range(0, 3) != 0);
         cgra_done = ($urandom_range(0, 7) == 0);
         tick();
      end
      req_valid = 1'b0;
      cgra_done = 1'b0;
      rsp_ready = 1'b1;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
